da_share_sched: RTL

- Round-robin scheduler that time-shares one bit-serial distributed-arithmetic (DA) sum-of-products core among NCH requesting channels.
- Each channel presents three B-bit two's-complement samples.
- The block grants one channel, loads its samples into the core, and sequences the B serial steps, asserting the sign-bit subtract step on the last one.
- It captures the core's accumulator and returns the result tagged with the channel number.
- It sits between the sample sources and the DA core, which holds its own LUT and accumulator.

---
 rtl/da_share_sched_if.sv | 37 +++
 rtl/da_share_sched.sv | 94 +++++++++
 2 files changed

// File: rtl/da_share_sched_if.sv
// Bundle between the sample sources, the scheduler and the DA core.
// slave is the scheduler view; master is the environment (sources + core) view.
interface da_share_sched_if #(
  parameter int NCH = 4,
  parameter int CW  = 2,
  parameter int B   = 4,
  parameter int W   = 7
);
  logic [NCH-1:0]   req;
  logic [NCH*B-1:0] x_in0;
  logic [NCH*B-1:0] x_in1;
  logic [NCH*B-1:0] x_in2;
  logic [NCH-1:0]   gnt;
  logic             da_load;
  logic             da_en;
  logic             da_last;
  logic [B-1:0]     da_x0;
  logic [B-1:0]     da_x1;
  logic [B-1:0]     da_x2;
  logic [W-1:0]     da_p;
  logic [W-1:0]     y;
  logic             y_valid;
  logic [CW-1:0]    y_ch;
  logic             busy;

  modport slave (
    input  req, x_in0, x_in1, x_in2, da_p,
    output gnt, da_load, da_en, da_last, da_x0, da_x1, da_x2,
           y, y_valid, y_ch, busy
  );

  modport master (
    output req, x_in0, x_in1, x_in2, da_p,
    input  gnt, da_load, da_en, da_last, da_x0, da_x1, da_x2,
           y, y_valid, y_ch, busy
  );
endinterface

// File: rtl/da_share_sched.sv
// Round-robin scheduler time-sharing one bit-serial DA core among NCH channels.
// Latency: req in IDLE -> gnt +1 -> y_valid +B+3; no backpressure, requests are not latched.
module da_share_sched #(
  parameter int NCH = 4,
  parameter int CW  = 2,
  parameter int B   = 4,
  parameter int W   = 7
) (
  input  logic             clk,
  input  logic             reset,
  da_share_sched_if.slave  bus
);
  localparam int CNTW = $clog2(B);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      state;
  logic [CW-1:0]   ptr;
  logic [CW-1:0]   win;
  logic [CW-1:0]   pick;
  logic [CW-1:0]   idx;
  logic            found;
  logic [CNTW-1:0] cnt;
  logic [W-1:0]    y_q;
  logic [CW-1:0]   y_ch_q;
  logic            y_valid_q;

  // Scan starts at ptr; CW-bit index arithmetic wraps modulo NCH.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = ptr + CW'(i);
      if (!found && bus.req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      win       <= '0;
      cnt       <= '0;
      y_q       <= '0;
      y_ch_q    <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            win   <= pick;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          cnt   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNTW'(B - 1)) state <= S_DONE;
        end
        S_DONE: begin
          y_q       <= bus.da_p;
          y_ch_q    <= win;
          y_valid_q <= 1'b1;
          ptr       <= win + 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode only registered state, so the samples are taken during LOAD itself.
  assign bus.gnt     = (state == S_LOAD) ? (NCH'(1) << win) : '0;
  assign bus.da_load = (state == S_LOAD);
  assign bus.da_en   = (state == S_RUN);
  assign bus.da_last = (state == S_RUN) && (cnt == CNTW'(B - 1));
  assign bus.da_x0   = (state == S_LOAD) ? bus.x_in0[win*B +: B] : '0;
  assign bus.da_x1   = (state == S_LOAD) ? bus.x_in1[win*B +: B] : '0;
  assign bus.da_x2   = (state == S_LOAD) ? bus.x_in2[win*B +: B] : '0;
  assign bus.busy    = (state != S_IDLE);
  assign bus.y       = y_q;
  assign bus.y_ch    = y_ch_q;
  assign bus.y_valid = y_valid_q;
endmodule
